// File: rtl/msxbus_pkg.sv
// Shared types and constants for the MSX slot bus bridge.
// Holds the FSM state enum, command bit positions and page-decode values.
package msxbus_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGetWd,
        StGetAl,
        StGetAh,
        StSetup,
        StStrobe,
        StHold,
        StResp
    } state_e;

    localparam int unsigned CmdWrBit   = 0;
    localparam int unsigned CmdIoBit   = 1;
    localparam int unsigned CmdSlotBit = 2;

    localparam logic [1:0] PAGE1 = 2'b01;
    localparam logic [1:0] PAGE2 = 2'b10;

    // All MSX control strobes/selects, active low.
    typedef struct packed {
        logic rd_n;
        logic wr_n;
        logic mreq_n;
        logic iorq_n;
        logic sltsl1_n;
        logic sltsl2_n;
        logic s1_cs1_n;
        logic s1_cs2_n;
        logic s1_cs12_n;
        logic s2_cs1_n;
        logic s2_cs2_n;
        logic s2_cs12_n;
    } bus_ctl_t;

    localparam bus_ctl_t BusIdle = '1;

endpackage

// File: rtl/msxbus_slot_decode.sv
// Combinational slot-select and page chip-select decoder.
// Selects only assert for memory cycles while the bus cycle is active.
module msxbus_slot_decode
    import msxbus_pkg::*;
(
    input  logic       active_i,
    input  logic       io_i,
    input  logic       slot_i,
    input  logic [1:0] page_i,
    output logic       sltsl1_n_o,
    output logic       sltsl2_n_o,
    output logic       s1_cs1_n_o,
    output logic       s1_cs2_n_o,
    output logic       s1_cs12_n_o,
    output logic       s2_cs1_n_o,
    output logic       s2_cs2_n_o,
    output logic       s2_cs12_n_o
);

    logic mem_sel;
    logic sel1;
    logic sel2;
    logic cs1;
    logic cs2;

    assign mem_sel = active_i & ~io_i;
    assign sel1    = mem_sel & ~slot_i;
    assign sel2    = mem_sel & slot_i;
    assign cs1     = (page_i == PAGE1);
    assign cs2     = (page_i == PAGE2);

    assign sltsl1_n_o  = ~sel1;
    assign sltsl2_n_o  = ~sel2;
    assign s1_cs1_n_o  = ~(sel1 & cs1);
    assign s1_cs2_n_o  = ~(sel1 & cs2);
    assign s1_cs12_n_o = ~(sel1 & (cs1 | cs2));
    assign s2_cs1_n_o  = ~(sel2 & cs1);
    assign s2_cs2_n_o  = ~(sel2 & cs2);
    assign s2_cs12_n_o = ~(sel2 & (cs1 | cs2));

endmodule

// File: rtl/msxbus_simple.sv
// Host byte-stream to MSX cartridge-slot bus bridge: collects a command, runs one
// memory or I/O cycle honouring /WAIT, and returns read data to the host.
module msxbus_simple
    import msxbus_pkg::*;
#(
    parameter int unsigned STROBE_CYC = 6,
    parameter int unsigned RESP_CYC   = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CS,
    input  logic        PCLK,
    inout  wire  [7:0]  RDATA,
    input  logic [1:0]  SW,
    input  logic        INT,
    input  logic        BUSDIR,
    input  logic        WAIT,
    inout  wire  [7:0]  DATA,
    output logic        RD,
    output logic        WR,
    output logic        MREQ,
    output logic        IORQ,
    output logic        RESET,
    output logic        RWAIT,
    output logic [15:0] ADDR,
    output logic        SLTSL1,
    output logic        SLTSL2,
    output logic        SLTSL1_CS1,
    output logic        SLTSL1_CS2,
    output logic        SLTSL1_CS12,
    output logic        SLTSL2_CS1,
    output logic        SLTSL2_CS2,
    output logic        SLTSL2_CS12,
    output logic        MCLK,
    output logic        SWOUT,
    output logic        RFSH,
    output logic        M1
);

    localparam int unsigned CntW = 8;
    localparam logic [CntW-1:0] StrobeLoad = CntW'(STROBE_CYC - 1);
    localparam logic [CntW-1:0] RespLoad   = CntW'(RESP_CYC - 1);

    state_e          state_q, state_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      addr_lo_q, addr_lo_d;
    logic [15:0]     addr_q, addr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      rd_data_q, rd_data_d;
    logic            rwait_q, rwait_d;
    logic            data_oe_q, data_oe_d;
    bus_ctl_t        bus_q, bus_d;

    logic [1:0] rst_sync_q;
    logic [1:0] wait_sync_q;
    logic [1:0] int_sync_q;
    logic [1:0] busdir_sync_q;
    logic [1:0] sw_sync_q;

    logic wait_n;
    logic bus_active;
    logic strobe_next;
    logic rdata_oe;
    logic dec_sltsl1_n, dec_sltsl2_n;
    logic dec_s1_cs1_n, dec_s1_cs2_n, dec_s1_cs12_n;
    logic dec_s2_cs1_n, dec_s2_cs2_n, dec_s2_cs12_n;
    logic unused_sig;

    // Reset output asserts asynchronously and releases two CLK edges later.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_sync_q    <= 2'b00;
            wait_sync_q   <= 2'b11;
            int_sync_q    <= 2'b11;
            busdir_sync_q <= 2'b11;
            sw_sync_q     <= 2'b00;
        end else begin
            rst_sync_q    <= {rst_sync_q[0], 1'b1};
            wait_sync_q   <= {wait_sync_q[0], WAIT};
            int_sync_q    <= {int_sync_q[0], INT};
            busdir_sync_q <= {busdir_sync_q[0], BUSDIR};
            sw_sync_q     <= {sw_sync_q[0], SW[0]};
        end
    end

    assign wait_n = wait_sync_q[1];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            cmd_q     <= 8'h00;
            wdata_q   <= 8'h00;
            addr_lo_q <= 8'h00;
            addr_q    <= 16'h0000;
            cnt_q     <= '0;
            rd_data_q <= 8'h00;
            rwait_q   <= 1'b1;
            data_oe_q <= 1'b0;
            bus_q     <= BusIdle;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            wdata_q   <= wdata_d;
            addr_lo_q <= addr_lo_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            rwait_q   <= rwait_d;
            data_oe_q <= data_oe_d;
            bus_q     <= bus_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        wdata_d   = wdata_q;
        addr_lo_d = addr_lo_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        unique case (state_q)
            StIdle: begin
                if (!CS && rwait_q) begin
                    cmd_d   = RDATA;
                    state_d = RDATA[CmdWrBit] ? StGetWd : StGetAl;
                end
            end
            StGetWd: begin
                if (CS) begin
                    state_d = StIdle;
                end else begin
                    wdata_d = RDATA;
                    state_d = StGetAl;
                end
            end
            StGetAl: begin
                if (CS) begin
                    state_d = StIdle;
                end else begin
                    addr_lo_d = RDATA;
                    state_d   = StGetAh;
                end
            end
            StGetAh: begin
                if (CS) begin
                    state_d = StIdle;
                end else begin
                    addr_d  = {RDATA, addr_lo_q};
                    state_d = StSetup;
                end
            end
            StSetup: begin
                cnt_d   = StrobeLoad;
                state_d = StStrobe;
            end
            StStrobe: begin
                // Synchronized /WAIT low freezes the strobe counter.
                if (wait_n) begin
                    if (cnt_q == '0) begin
                        state_d = StHold;
                        if (!cmd_q[CmdWrBit]) begin
                            rd_data_d = DATA;
                        end
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end
            StHold: begin
                if (cmd_q[CmdWrBit]) begin
                    state_d = StIdle;
                end else begin
                    cnt_d   = RespLoad;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus controls are registered from the next state so they change glitch-free.
    assign bus_active  = (state_d == StSetup) || (state_d == StStrobe);
    assign strobe_next = (state_d == StStrobe);

    msxbus_slot_decode u_slot_decode (
        .active_i    (bus_active),
        .io_i        (cmd_d[CmdIoBit]),
        .slot_i      (cmd_d[CmdSlotBit]),
        .page_i      (addr_d[15:14]),
        .sltsl1_n_o  (dec_sltsl1_n),
        .sltsl2_n_o  (dec_sltsl2_n),
        .s1_cs1_n_o  (dec_s1_cs1_n),
        .s1_cs2_n_o  (dec_s1_cs2_n),
        .s1_cs12_n_o (dec_s1_cs12_n),
        .s2_cs1_n_o  (dec_s2_cs1_n),
        .s2_cs2_n_o  (dec_s2_cs2_n),
        .s2_cs12_n_o (dec_s2_cs12_n)
    );

    always_comb begin
        bus_d           = BusIdle;
        bus_d.rd_n      = ~(strobe_next & ~cmd_d[CmdWrBit]);
        bus_d.wr_n      = ~(strobe_next & cmd_d[CmdWrBit]);
        bus_d.mreq_n    = ~(bus_active & ~cmd_d[CmdIoBit]);
        bus_d.iorq_n    = ~(bus_active & cmd_d[CmdIoBit]);
        bus_d.sltsl1_n  = dec_sltsl1_n;
        bus_d.sltsl2_n  = dec_sltsl2_n;
        bus_d.s1_cs1_n  = dec_s1_cs1_n;
        bus_d.s1_cs2_n  = dec_s1_cs2_n;
        bus_d.s1_cs12_n = dec_s1_cs12_n;
        bus_d.s2_cs1_n  = dec_s2_cs1_n;
        bus_d.s2_cs2_n  = dec_s2_cs2_n;
        bus_d.s2_cs12_n = dec_s2_cs12_n;
        rwait_d   = state_d inside {StIdle, StGetWd, StGetAl, StGetAh};
        data_oe_d = cmd_d[CmdWrBit] & (state_d inside {StSetup, StStrobe, StHold});
    end

    assign rdata_oe = (state_q == StResp) && !CS && !data_oe_q;
    assign RDATA    = rdata_oe ? rd_data_q : 8'hzz;
    assign DATA     = data_oe_q ? wdata_q : 8'hzz;

    assign RD          = bus_q.rd_n;
    assign WR          = bus_q.wr_n;
    assign MREQ        = bus_q.mreq_n;
    assign IORQ        = bus_q.iorq_n;
    assign SLTSL1      = bus_q.sltsl1_n;
    assign SLTSL2      = bus_q.sltsl2_n;
    assign SLTSL1_CS1  = bus_q.s1_cs1_n;
    assign SLTSL1_CS2  = bus_q.s1_cs2_n;
    assign SLTSL1_CS12 = bus_q.s1_cs12_n;
    assign SLTSL2_CS1  = bus_q.s2_cs1_n;
    assign SLTSL2_CS2  = bus_q.s2_cs2_n;
    assign SLTSL2_CS12 = bus_q.s2_cs12_n;

    assign ADDR  = addr_q;
    assign RWAIT = rwait_q;
    assign RESET = rst_sync_q[1];
    assign SWOUT = sw_sync_q[1];
    assign MCLK  = PCLK;
    assign RFSH  = 1'b1;
    assign M1    = 1'b1;

    // Synchronized but otherwise unused inputs and ignored command bits.
    assign unused_sig = ^{int_sync_q, busdir_sync_q, SW[1], cmd_q[7:3]};

endmodule

// File: tb/tb_msxbus_simple.sv
// Randomized self-checking bench for msxbus_simple against a behavioural bus model.
module tb_msxbus_simple;

    localparam int STROBE_CYC = 6;
    localparam int RESP_CYC   = 2;

    logic clk = 1'b0;
    logic pclk = 1'b0;
    logic rst_n = 1'b0;
    logic cs_n = 1'b1;
    logic [1:0] sw = 2'b00;
    logic int_n = 1'b1;
    logic busdir_n = 1'b1;
    logic wait_n = 1'b1;
    logic host_oe = 1'b0;
    logic [7:0] host_byte = 8'h00;
    logic [7:0] tb_rdval = 8'h00;

    wire [7:0] rdata_bus;
    wire [7:0] data_bus;
    logic rd_n, wr_n, mreq_n, iorq_n, reset_n, rwait;
    logic [15:0] addr;
    logic sl1, sl2, s1c1, s1c2, s1c12, s2c1, s2c2, s2c12;
    logic mclk, swout, rfsh_n, m1_n;

    assign rdata_bus = host_oe ? host_byte : 8'hzz;
    assign data_bus  = (!rd_n) ? tb_rdval : 8'hzz;

    always #10 clk = ~clk;
    always #7 pclk = ~pclk;

    msxbus_simple #(.STROBE_CYC(STROBE_CYC), .RESP_CYC(RESP_CYC)) dut (
        .CLK(clk), .RST_N(rst_n), .CS(cs_n), .PCLK(pclk), .RDATA(rdata_bus), .SW(sw),
        .INT(int_n), .BUSDIR(busdir_n), .WAIT(wait_n), .DATA(data_bus),
        .RD(rd_n), .WR(wr_n), .MREQ(mreq_n), .IORQ(iorq_n), .RESET(reset_n),
        .RWAIT(rwait), .ADDR(addr), .SLTSL1(sl1), .SLTSL2(sl2),
        .SLTSL1_CS1(s1c1), .SLTSL1_CS2(s1c2), .SLTSL1_CS12(s1c12),
        .SLTSL2_CS1(s2c1), .SLTSL2_CS2(s2c2), .SLTSL2_CS12(s2c12),
        .MCLK(mclk), .SWOUT(swout), .RFSH(rfsh_n), .M1(m1_n)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of one bus transaction.
    bit         obs_timeout, obs_done, obs_rwait_ah, obs_data_bad, obs_hold_idle;
    int         obs_rd_len, obs_wr_len, obs_setup_len, obs_post_n;
    logic [15:0] obs_addr, obs_hold_addr;
    logic       obs_mreq, obs_iorq;
    logic [7:0] obs_sel, obs_hold_data;
    logic [7:0] obs_post [8];

    // Model: expected {SLTSL1,SLTSL2,S1CS1,S1CS2,S1CS12,S2CS1,S2CS2,S2CS12} during a cycle.
    function automatic logic [7:0] exp_sel(input logic [7:0] cmd, input logic [15:0] a);
        bit mem = (cmd[1] == 1'b0);
        bit s1 = mem && (cmd[2] == 1'b0);
        bit s2 = mem && (cmd[2] == 1'b1);
        bit p1 = (a[15:14] == 2'd1);
        bit p2 = (a[15:14] == 2'd2);
        return ~{s1, s2, s1 && p1, s1 && p2, s1 && (p1 || p2), s2 && p1, s2 && p2,
                 s2 && (p1 || p2)};
    endfunction

    task automatic bus_txn(input logic [7:0] cmd, input logic [7:0] wdata,
                           input logic [15:0] a, input int wcyc, input logic [7:0] rdval,
                           input bit junk);
        logic [7:0] bytes[$];
        int waited = 0;
        bit strobe_seen = 0;
        bit hold_seen = 0;
        bytes = {cmd};
        if (cmd[0]) bytes.push_back(wdata);
        bytes.push_back(a[7:0]);
        bytes.push_back(a[15:8]);
        obs_timeout = 0; obs_done = 0; obs_data_bad = 0; obs_hold_idle = 0;
        obs_rd_len = 0; obs_wr_len = 0; obs_setup_len = 0; obs_post_n = 0;
        obs_addr = 'x; obs_hold_addr = 'x; obs_sel = 'x; obs_hold_data = 'x;
        for (int i = 0; i < 8; i++) obs_post[i] = 8'h00;
        tb_rdval = rdval;
        foreach (bytes[i]) begin
            @(negedge clk);
            cs_n = 1'b0; host_oe = 1'b1; host_byte = bytes[i];
        end
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (n == 0) begin
                obs_rwait_ah = rwait;
                if (cmd[0] && !junk) cs_n = 1'b1;
            end
            if (junk && !rwait) host_byte = 8'($urandom);
            else host_oe = 1'b0;
            if (!rd_n || !wr_n) begin
                if (!strobe_seen) begin
                    obs_addr = addr; obs_mreq = mreq_n; obs_iorq = iorq_n;
                    obs_sel = {sl1, sl2, s1c1, s1c2, s1c12, s2c1, s2c2, s2c12};
                end
                strobe_seen = 1;
                if (!rd_n) obs_rd_len++;
                if (!wr_n) begin
                    obs_wr_len++;
                    if (data_bus !== wdata) obs_data_bad = 1;
                end
            end else if (!strobe_seen) begin
                if (!mreq_n || !iorq_n) obs_setup_len++;
            end else begin
                if (!hold_seen) begin
                    hold_seen = 1;
                    obs_hold_idle = &{mreq_n, iorq_n, sl1, sl2, s1c1, s1c2, s1c12, s2c1,
                                      s2c2, s2c12};
                    obs_hold_addr = addr;
                    obs_hold_data = data_bus;
                end
                if (rwait) begin
                    obs_done = 1; cs_n = 1'b1; host_oe = 1'b0; wait_n = 1'b1;
                    break;
                end
                if (obs_post_n < 8) obs_post[obs_post_n] = rdata_bus;
                obs_post_n++;
            end
            if (strobe_seen && waited < wcyc) begin
                wait_n = 1'b0; waited++;
            end else begin
                wait_n = 1'b1;
            end
        end
        if (!obs_done) obs_timeout = 1;
        cs_n = 1'b1; host_oe = 1'b0; wait_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({rd_n, wr_n, mreq_n, iorq_n, sl1, sl2, s1c1, s1c2, s1c12, s2c1, s2c2, s2c12,
             rwait, rfsh_n, m1_n} !== 15'h7FFF) begin
            n_fail++; $display("FAIL reset_ctl got=%b required=all ones",
                {rd_n, wr_n, mreq_n, iorq_n, sl1, sl2, s1c1, s1c2, s1c12, rwait});
        end
        n_checks++;
        if (addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr got=%h required=0000", addr); end
        n_checks++;
        if (reset_n !== 1'b0) begin n_fail++; $display("FAIL reset_out got=%b required=0", reset_n); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (reset_n !== 1'b0) begin n_fail++; $display("FAIL reset_sync1 got=%b required=0", reset_n); end
        @(negedge clk);
        n_checks++;
        if (reset_n !== 1'b1) begin n_fail++; $display("FAIL reset_sync2 got=%b required=1", reset_n); end
    endtask

    task automatic test_static();
        for (int i = 0; i < 6; i++) begin
            #3;
            n_checks++;
            if ({mclk, rfsh_n, m1_n} !== {pclk, 2'b11}) begin
                n_fail++; $display("FAIL static got=%b required=%b", {mclk, rfsh_n, m1_n}, {pclk, 2'b11});
            end
        end
        for (int i = 0; i < 2; i++) begin
            sw = (i == 0) ? 2'b01 : 2'b10;
            repeat (3) @(negedge clk);
            n_checks++;
            if (swout !== sw[0]) begin n_fail++; $display("FAIL swout got=%b required=%b", swout, sw[0]); end
        end
    endtask

    task automatic test_read();
        logic [7:0] cmd, rv; logic [15:0] a; int w;
        for (int it = 0; it < 7; it++) begin
            if (it == 0) begin cmd = 8'h00; a = 16'h4034; rv = 8'hAA; w = 2; end
            else begin
                cmd = 8'($urandom) & 8'hFE; a = 16'($urandom);
                rv = 8'($urandom_range(1, 254)); w = $urandom_range(0, 3);
            end
            bus_txn(cmd, 8'h00, a, w, rv, 1'b0);
            n_checks++;
            if (obs_timeout) begin n_fail++; $display("FAIL read_timeout it=%0d got=timeout required=done", it); continue; end
            n_checks++;
            if (obs_addr !== a) begin n_fail++; $display("FAIL read_addr it=%0d got=%h required=%h", it, obs_addr, a); end
            n_checks++;
            if ({obs_mreq, obs_iorq} !== {cmd[1], ~cmd[1]}) begin
                n_fail++; $display("FAIL read_mreq_iorq it=%0d got=%b required=%b", it, {obs_mreq, obs_iorq}, {cmd[1], ~cmd[1]});
            end
            n_checks++;
            if (obs_sel !== exp_sel(cmd, a)) begin n_fail++; $display("FAIL read_sel it=%0d got=%b required=%b", it, obs_sel, exp_sel(cmd, a)); end
            n_checks++;
            if (obs_rd_len != STROBE_CYC + w || obs_wr_len != 0) begin
                n_fail++; $display("FAIL read_strobe_len it=%0d got=rd%0d/wr%0d required=rd%0d/wr0", it, obs_rd_len, obs_wr_len, STROBE_CYC + w);
            end
            n_checks++;
            if (obs_setup_len != 1 || obs_rwait_ah !== 1'b0) begin
                n_fail++; $display("FAIL read_setup it=%0d got=setup%0d rwait%b required=setup1 rwait0", it, obs_setup_len, obs_rwait_ah);
            end
            n_checks++;
            if (!obs_hold_idle || obs_hold_addr !== a) begin
                n_fail++; $display("FAIL read_hold it=%0d got=idle%b addr%h required=idle1 addr%h", it, obs_hold_idle, obs_hold_addr, a);
            end
            n_checks++;
            if (obs_post_n != 1 + RESP_CYC) begin n_fail++; $display("FAIL read_resp_len it=%0d got=%0d required=%0d", it, obs_post_n, 1 + RESP_CYC); end
            for (int i = 1; i <= RESP_CYC; i++) begin
                n_checks++;
                if (obs_post[i] !== rv) begin n_fail++; $display("FAIL read_rdata it=%0d got=%h required=%h", it, obs_post[i], rv); end
            end
        end
    endtask

    task automatic test_write();
        logic [7:0] cmd, wd; logic [15:0] a; int w;
        for (int it = 0; it < 8; it++) begin
            if (it == 0) begin cmd = 8'h01; wd = 8'hBB; a = 16'h8056; w = 0; end
            else if (it == 1) begin cmd = 8'h07; wd = 8'h5A; a = 16'h0098; w = 0; end
            else begin cmd = 8'($urandom) | 8'h01; wd = 8'($urandom); a = 16'($urandom); w = $urandom_range(0, 3); end
            bus_txn(cmd, wd, a, w, 8'h00, 1'b0);
            n_checks++;
            if (obs_timeout) begin n_fail++; $display("FAIL write_timeout it=%0d got=timeout required=done", it); continue; end
            n_checks++;
            if (obs_addr !== a) begin n_fail++; $display("FAIL write_addr it=%0d got=%h required=%h", it, obs_addr, a); end
            n_checks++;
            if ({obs_mreq, obs_iorq} !== {cmd[1], ~cmd[1]}) begin
                n_fail++; $display("FAIL write_mreq_iorq it=%0d got=%b required=%b", it, {obs_mreq, obs_iorq}, {cmd[1], ~cmd[1]});
            end
            n_checks++;
            if (obs_sel !== exp_sel(cmd, a)) begin n_fail++; $display("FAIL write_sel it=%0d got=%b required=%b", it, obs_sel, exp_sel(cmd, a)); end
            n_checks++;
            if (obs_wr_len != STROBE_CYC + w || obs_rd_len != 0) begin
                n_fail++; $display("FAIL write_strobe_len it=%0d got=wr%0d/rd%0d required=wr%0d/rd0", it, obs_wr_len, obs_rd_len, STROBE_CYC + w);
            end
            n_checks++;
            if (obs_data_bad || obs_hold_data !== wd) begin
                n_fail++; $display("FAIL write_data it=%0d got=hold%h bad%b required=%h", it, obs_hold_data, obs_data_bad, wd);
            end
            n_checks++;
            if (!obs_hold_idle || obs_post_n != 1 || obs_rwait_ah !== 1'b0) begin
                n_fail++; $display("FAIL write_hold it=%0d got=idle%b post%0d rwait%b required=idle1 post1 rwait0", it, obs_hold_idle, obs_post_n, obs_rwait_ah);
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] seq [3][3];
        int len [3];
        int bad;
        logic [15:0] a;
        seq[0] = '{8'h00, 8'h12, 8'h00}; len[0] = 2;
        seq[1] = '{8'h01, 8'h77, 8'h34}; len[1] = 3;
        seq[2] = '{8'h03, 8'h00, 8'h00}; len[2] = 1;
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < len[it]; i++) begin
                @(negedge clk); cs_n = 1'b0; host_oe = 1'b1; host_byte = seq[it][i];
            end
            @(negedge clk); cs_n = 1'b1; host_oe = 1'b0;
            bad = 0;
            repeat (8) begin
                @(negedge clk);
                if (!rd_n || !wr_n || !mreq_n || !iorq_n || !rwait) bad++;
            end
            n_checks++;
            if (bad != 0) begin n_fail++; $display("FAIL abort_quiet it=%0d got=%0d active cycles required=0", it, bad); end
            a = 16'($urandom);
            bus_txn(8'h00, 8'h00, a, 0, 8'h3C, 1'b0);
            n_checks++;
            if (obs_timeout || obs_addr !== a || obs_rd_len != STROBE_CYC) begin
                n_fail++; $display("FAIL abort_next it=%0d got=addr%h rd%0d to%b required=addr%h rd%0d", it, obs_addr, obs_rd_len, obs_timeout, a, STROBE_CYC);
            end
        end
    endtask

    task automatic test_busy();
        logic [15:0] a;
        int bad = 0;
        a = 16'($urandom);
        bus_txn(8'h01, 8'hC3, a, 1, 8'h00, 1'b1);
        n_checks++;
        if (obs_timeout || obs_addr !== a || obs_hold_addr !== a || obs_wr_len != STROBE_CYC + 1) begin
            n_fail++; $display("FAIL busy_txn got=addr%h hold%h wr%0d required=addr%h wr%0d", obs_addr, obs_hold_addr, obs_wr_len, a, STROBE_CYC + 1);
        end
        repeat (6) begin
            @(negedge clk);
            if (addr !== a || !wr_n || !mreq_n || !rwait) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL busy_ignored got=%0d bad cycles required=0", bad); end
    endtask

    task automatic test_reset_mid_strobe();
        logic [7:0] b [4];
        bit seen = 0;
        b = '{8'h01, 8'h99, 8'h00, 8'h40};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); cs_n = 1'b0; host_oe = 1'b1; host_byte = b[i];
        end
        @(negedge clk); cs_n = 1'b1; host_oe = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (!wr_n) begin seen = 1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL rst_mid_strobe_start got=no WR required=WR low"); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({wr_n, rd_n, mreq_n, iorq_n, rwait, sl1, s1c1, s1c12} !== 8'hFF) begin
            n_fail++; $display("FAIL rst_mid_ctl got=%b required=11111111", {wr_n, rd_n, mreq_n, iorq_n, rwait, sl1, s1c1, s1c12});
        end
        n_checks++;
        if (addr !== 16'h0000 || reset_n !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_addr got=addr%h reset%b required=addr0000 reset0", addr, reset_n);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (reset_n !== 1'b1) begin n_fail++; $display("FAIL rst_mid_release got=%b required=1", reset_n); end
        bus_txn(8'h04, 8'h00, 16'h4321, 0, 8'h5E, 1'b0);
        n_checks++;
        if (obs_timeout || obs_post[1] !== 8'h5E || obs_sel !== exp_sel(8'h04, 16'h4321)) begin
            n_fail++; $display("FAIL rst_mid_recover got=rdata%h sel%b required=rdata5e sel%b", obs_post[1], obs_sel, exp_sel(8'h04, 16'h4321));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_static();
        test_read();
        test_write();
        test_abort();
        test_busy();
        test_reset_mid_strobe();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
